trackball_decoder: RTL and testbench

TRACKBALL_DECODER -- requirements
Module: trackball_decoder

---
 rtl/trackball_decoder.sv | 116 +++++++++++
 tb/tb_trackball_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/trackball_decoder.sv
// rtl/trackball_decoder.sv - two-axis quadrature trackball decoder with glitch filters and CPU read port
// Inputs are synchronized, filtered on ce, then Gray-decoded into wrapping 8-bit counts per axis.
module trackball_decoder #(
  parameter int FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       X1,
  input  logic       Y1,
  input  logic       X2,
  input  logic       Y2,
  input  logic       rd,
  input  logic [1:0] addr,
  output logic [7:0] data
);

  // Bit order everywhere: [0]=X1 [1]=Y1 [2]=X2 [3]=Y2
  logic [3:0]      raw;
  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      filt_q, filt_d;
  logic [3:0][3:0] fcnt_q, fcnt_d;
  logic [1:0]      prev0_q, prev1_q;
  logic [1:0]      cur0, cur1;
  logic [7:0]      cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic            err0_q, err0_d, err1_q, err1_d;
  logic [7:0]      data_q, data_d;
  logic            clr_err;

  assign raw  = {Y2, X2, Y1, X1};
  assign cur0 = {filt_q[0], filt_q[1]};
  assign cur1 = {filt_q[2], filt_q[3]};

  // Forward successor in the {A,B} sequence 00->01->11->10->00
  function automatic logic [1:0] gray_next(input logic [1:0] s);
    case (s)
      2'b00:   gray_next = 2'b01;
      2'b01:   gray_next = 2'b11;
      2'b11:   gray_next = 2'b10;
      default: gray_next = 2'b00;
    endcase
  endfunction

  function automatic logic [7:0] step_count(input logic [1:0] p, input logic [1:0] c,
                                            input logic [7:0] cnt);
    if (p == c || (p ^ c) == 2'b11) step_count = cnt;
    else if (c == gray_next(p))     step_count = cnt + 8'd1;
    else                            step_count = cnt - 8'd1;
  endfunction

  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    if (ce) begin
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] != filt_q[i]) begin
          if (fcnt_q[i] == 4'(FILTER_LEN - 1)) begin
            filt_d[i] = sync2_q[i];
            fcnt_d[i] = 4'd0;
          end else begin
            fcnt_d[i] = fcnt_q[i] + 4'd1;
          end
        end else begin
          fcnt_d[i] = 4'd0;
        end
      end
    end
  end

  // A set in the same clk as a clear must survive, hence OR after the mask
  assign clr_err = rd && (addr == 2'd2);

  always_comb begin
    cnt0_d = step_count(prev0_q, cur0, cnt0_q);
    cnt1_d = step_count(prev1_q, cur1, cnt1_q);
    err0_d = ((prev0_q ^ cur0) == 2'b11) | (err0_q & ~clr_err);
    err1_d = ((prev1_q ^ cur1) == 2'b11) | (err1_q & ~clr_err);
    case (addr)
      2'd0:    data_d = cnt0_q;
      2'd1:    data_d = cnt1_q;
      2'd2:    data_d = {6'b0, err1_q, err0_q};
      default: data_d = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      fcnt_q  <= '0;
      prev0_q <= '0;
      prev1_q <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
      prev0_q <= cur0;
      prev1_q <= cur1;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      data_q  <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: tb/tb_trackball_decoder.sv
// tb/tb_trackball_decoder.sv - scoreboard bench for trackball_decoder
// Expected read data comes from a Gray-position model updated as inputs are driven.
module tb_trackball_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce = 1'b0;
  logic       X1 = 1'b0, Y1 = 1'b0, X2 = 1'b0, Y2 = 1'b0;
  logic       rd = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] data;

  int checks = 0;
  int errors = 0;
  int ce_period = 1;
  int ce_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] m_cnt0 = 8'h00, m_cnt1 = 8'h00;
  logic       m_err0 = 1'b0, m_err1 = 1'b0;
  logic [1:0] m_st0 = 2'b00, m_st1 = 2'b00;

  trackball_decoder #(.FILTER_LEN(3)) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce),
    .X1(X1), .Y1(Y1), .X2(X2), .Y2(Y2),
    .rd(rd), .addr(addr), .data(data)
  );

  always #50 clk = ~clk;

  always @(negedge clk) begin
    ce_cnt = ce_cnt + 1;
    ce = ((ce_cnt % ce_period) == 0);
  end

  // Position in the cycle 00,01,11,10; the distance between positions gives direction
  function automatic int gray_pos(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_axis(input logic [1:0] nxt, inout logic [1:0] st,
                            inout logic [7:0] cnt, inout logic err);
    int d;
    d = (gray_pos(nxt) - gray_pos(st) + 4) % 4;
    if (d == 1) cnt = cnt + 8'd1;
    else if (d == 3) cnt = cnt - 8'd1;
    else if (d == 2) err = 1'b1;
    st = nxt;
  endtask

  task automatic model_reset();
    m_cnt0 = 8'h00; m_cnt1 = 8'h00;
    m_err0 = 1'b0;  m_err1 = 1'b0;
    m_st0  = 2'b00; m_st1  = 2'b00;
  endtask

  task automatic set_inputs(input logic x1, input logic y1, input logic x2, input logic y2,
                            input int hold);
    @(negedge clk);
    X1 = x1; Y1 = y1; X2 = x2; Y2 = y2;
    model_axis({x1, y1}, m_st0, m_cnt0, m_err0);
    model_axis({x2, y2}, m_st1, m_cnt1, m_err1);
    repeat (hold) @(negedge clk);
  endtask

  task automatic do_read(input logic [1:0] a, input logic r, input string nm);
    logic [7:0] e;
    logic [7:0] got;
    @(negedge clk);
    addr = a; rd = r;
    case (a)
      2'd0:    e = m_cnt0;
      2'd1:    e = m_cnt1;
      2'd2:    e = {6'b0, m_err1, m_err0};
      default: e = 8'hFF;
    endcase
    exp_q.push_back(e);
    if (r && a == 2'd2) begin
      m_err0 = 1'b0;
      m_err1 = 1'b0;
    end
    @(negedge clk);
    rd = 1'b0;
    got = data;
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: data=%h expected=%h", nm, got, e);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: data=%h expected=00", data);
    end
    reset_n = 1'b1;
    model_reset();
    do_read(2'd0, 1'b0, "reset_addr0");
    do_read(2'd1, 1'b0, "reset_addr1");
    do_read(2'd2, 1'b0, "reset_addr2");
    do_read(2'd3, 1'b0, "reset_addr3");
  endtask

  task automatic test_forward_axis0();
    set_inputs(0, 1, 0, 0, 10);
    set_inputs(1, 1, 0, 0, 10);
    set_inputs(1, 0, 0, 0, 10);
    set_inputs(0, 0, 0, 0, 10);
    do_read(2'd0, 1'b0, "fwd4_count0");
    do_read(2'd2, 1'b0, "fwd4_err");
  endtask

  task automatic test_reverse_axis1();
    set_inputs(0, 0, 1, 0, 10);
    do_read(2'd1, 1'b0, "rev_wrap_count1");
    set_inputs(0, 0, 0, 0, 10);
    set_inputs(0, 0, 0, 1, 10);
    do_read(2'd1, 1'b0, "fwd_wrap_count1");
    set_inputs(0, 0, 0, 0, 10);
    do_read(2'd1, 1'b0, "back_to_zero_count1");
  endtask

  task automatic test_glitch();
    @(negedge clk);
    X1 = 1'b1;
    repeat (2) @(negedge clk);
    X1 = 1'b0;
    repeat (10) @(negedge clk);
    do_read(2'd0, 1'b0, "glitch_count0");
    do_read(2'd2, 1'b0, "glitch_err");
  endtask

  task automatic test_double_error();
    set_inputs(1, 1, 0, 0, 10);
    do_read(2'd0, 1'b0, "dbl_count0");
    do_read(2'd2, 1'b0, "dbl_err_peek");
    do_read(2'd2, 1'b1, "dbl_err_clear_read");
    do_read(2'd2, 1'b0, "dbl_err_after_clear");
    set_inputs(1, 0, 0, 0, 10);
    set_inputs(0, 0, 0, 0, 10);
    do_read(2'd0, 1'b0, "post_err_count0");
  endtask

  task automatic test_reset_mid();
    set_inputs(1, 0, 0, 0, 10);
    do_read(2'd0, 1'b0, "pre_reset_count0");
    @(negedge clk);
    Y1 = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    X1 = 1'b0; Y1 = 1'b0;
    @(negedge clk);
    checks++;
    if (data !== 8'h00) begin
      errors++;
      $display("FAIL midreset_data: data=%h expected=00", data);
    end
    reset_n = 1'b1;
    model_reset();
    do_read(2'd0, 1'b0, "midreset_addr0");
    do_read(2'd1, 1'b0, "midreset_addr1");
    do_read(2'd2, 1'b0, "midreset_addr2");
    do_read(2'd3, 1'b0, "midreset_addr3");
    repeat (10) @(negedge clk);
    do_read(2'd0, 1'b0, "midreset_settled_addr0");
  endtask

  task automatic test_slow_ce();
    logic [7:0] got;
    ce_period = 4;
    @(negedge clk);
    Y1 = 1'b1;
    repeat (8) @(negedge clk);
    Y1 = 1'b0;
    repeat (12) @(negedge clk);
    do_read(2'd0, 1'b0, "slow_reject_count0");
    do_read(2'd2, 1'b0, "slow_reject_err");
    set_inputs(0, 1, 0, 0, 6);
    addr = 2'd0;
    @(negedge clk);
    got = data;
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL slow_early_count0: data=%h expected=00", got);
    end
    repeat (20) @(negedge clk);
    do_read(2'd0, 1'b0, "slow_accept_count0");
  endtask

  task automatic test_both_axes();
    ce_period = 1;
    repeat (4) @(negedge clk);
    set_inputs(1, 1, 0, 1, 10);
    do_read(2'd0, 1'b0, "both_count0");
    do_read(2'd1, 1'b0, "both_count1");
    do_read(2'd2, 1'b0, "both_err");
  endtask

  initial begin
    test_reset();
    test_forward_axis0();
    test_reverse_axis1();
    test_glitch();
    test_double_error();
    test_reset_mid();
    test_slow_ce();
    test_both_axes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
